// File: rtl/cpu_pkg.sv
// Shared encodings for the decode pipeline: opcodes, ALU operations, operand selects
// and the control state, plus the opcode-to-control decode table.
package cpu_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_ADD  = 4'h1,
        OP_SUB  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_ADDI = 4'h5,
        OP_SUBI = 4'h6,
        OP_INCR = 4'h7,
        OP_DECR = 4'h8,
        OP_LDI  = 4'h9,
        OP_LD   = 4'hA,
        OP_ST   = 4'hB,
        OP_BEQ  = 4'hC,
        OP_BGT  = 4'hD,
        OP_JUMP = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        SRC1_ZERO,
        SRC1_RD,
        SRC1_RS,
        SRC1_PC
    } src1_sel_e;

    typedef enum logic [2:0] {
        SRC2_ZERO,
        SRC2_RS,
        SRC2_IMM,
        SRC2_DISP,
        SRC2_ONE
    } src2_sel_e;

    typedef struct packed {
        logic [1:0] alu_op;
        src1_sel_e  src1_sel;
        src2_sel_e  src2_sel;
        logic       writes_rd;
        logic       use_rd;
        logic       use_rs;
        logic       is_eq;
        logic       mem_w;
        logic       pc_w;
        logic       is_ldi;
        logic       is_ld_st;
        logic       is_jump;
        logic       is_halt;
    } ctrl_t;

    // use_rd/use_rs mark the registers an opcode reads, which drive the hazard check.
    function automatic ctrl_t decode_op(input opcode_e op);
        ctrl_t c;
        c = '{alu_op: ALU_ADD, src1_sel: SRC1_ZERO, src2_sel: SRC2_ZERO, default: 1'b0};
        case (op)
            OP_NOP: ;
            OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                c.alu_op    = (op == OP_ADD) ? ALU_ADD :
                              (op == OP_SUB) ? ALU_SUB :
                              (op == OP_AND) ? ALU_AND : ALU_OR;
                c.src1_sel  = SRC1_RD;
                c.src2_sel  = SRC2_RS;
                c.writes_rd = 1'b1;
                c.use_rd    = 1'b1;
                c.use_rs    = 1'b1;
            end
            OP_ADDI, OP_SUBI: begin
                c.alu_op    = (op == OP_SUBI) ? ALU_SUB : ALU_ADD;
                c.src1_sel  = SRC1_RD;
                c.src2_sel  = SRC2_IMM;
                c.writes_rd = 1'b1;
                c.use_rd    = 1'b1;
            end
            OP_INCR, OP_DECR: begin
                c.alu_op    = (op == OP_DECR) ? ALU_SUB : ALU_ADD;
                c.src1_sel  = SRC1_RD;
                c.src2_sel  = SRC2_ONE;
                c.writes_rd = 1'b1;
                c.use_rd    = 1'b1;
            end
            OP_LDI: begin
                c.src2_sel  = SRC2_IMM;
                c.writes_rd = 1'b1;
                c.is_ldi    = 1'b1;
            end
            OP_LD: begin
                c.src1_sel  = SRC1_RS;
                c.src2_sel  = SRC2_DISP;
                c.writes_rd = 1'b1;
                c.use_rs    = 1'b1;
                c.is_ld_st  = 1'b1;
            end
            OP_ST: begin
                c.src1_sel  = SRC1_RS;
                c.src2_sel  = SRC2_DISP;
                c.use_rd    = 1'b1;
                c.use_rs    = 1'b1;
                c.is_ld_st  = 1'b1;
                c.mem_w     = 1'b1;
            end
            OP_BEQ, OP_BGT: begin
                c.src1_sel  = SRC1_PC;
                c.src2_sel  = SRC2_DISP;
                c.use_rd    = 1'b1;
                c.use_rs    = 1'b1;
                c.pc_w      = 1'b1;
                c.is_eq     = (op == OP_BEQ);
            end
            OP_JUMP: begin
                c.src1_sel  = SRC1_PC;
                c.src2_sel  = SRC2_IMM;
                c.pc_w      = 1'b1;
                c.is_jump   = 1'b1;
            end
            OP_HALT: begin
                c.is_halt   = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Register file with two combinational read ports, one write port and write-through
// bypass; register 0 always reads as zero and ignores writes.
module regfile_bypass #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    localparam int AW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [AW-1:0]     raddr_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    // A write landing this cycle is forwarded so the reader never sees a stale value.
    always_comb begin
        rdata_a = '0;
        rdata_b = '0;
        if (raddr_a != '0) begin
            rdata_a = (we && (waddr == raddr_a)) ? wdata : regs[raddr_a];
        end
        if (raddr_b != '0) begin
            rdata_b = (we && (waddr == raddr_b)) ? wdata : regs[raddr_b];
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// Single-entry decode/issue stage: holds one instruction, checks it against the pending
// scoreboard, reads operands (with writeback bypass) and presents decoded controls.
module decode_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NREG     = 8,
    parameter int SEXT_IMM = 0,
    localparam int REG_AW  = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       inst,
    input  logic [DATA_W-1:0] pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              is_eq,
    output logic              mem_w,
    output logic              pc_w,
    output logic              is_ldi,
    output logic              is_ld_st,
    output logic              is_jump,
    output logic              halted,
    output logic [1:0]        alu_op,
    output logic [REG_AW-1:0] rd_addr,
    output logic [DATA_W-1:0] source1,
    output logic [DATA_W-1:0] source2,
    output logic [DATA_W-1:0] rd_val,
    output logic [DATA_W-1:0] rs_val,
    output logic [DATA_W-1:0] pc_out,
    input  logic              wb_en,
    input  logic              wb_nowrite,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              flush
);

    state_e            state;
    state_e            state_next;
    logic [15:0]       ir;
    logic [DATA_W-1:0] ir_pc;
    logic              ir_valid;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   wb_clr_mask;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   live_pending;
    opcode_e           op;
    ctrl_t             ctrl;
    logic [REG_AW-1:0] rd_idx;
    logic [REG_AW-1:0] rs_idx;
    logic [REG_AW-1:0] rd_sel;
    logic [DATA_W-1:0] disp_ext;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] rs_data;
    logic              hazard;
    logic              accept;
    logic              issue;

    assign op     = opcode_e'(ir[15:12]);
    assign ctrl   = decode_op(op);
    assign rd_idx = REG_AW'(ir[11:9]);
    assign rs_idx = REG_AW'(ir[8:6]);
    assign rd_sel = ctrl.writes_rd ? rd_idx : '0;

    assign disp_ext = (SEXT_IMM != 0) ? {{(DATA_W-6){ir[5]}}, ir[5:0]}
                                      : {{(DATA_W-6){1'b0}}, ir[5:0]};
    assign imm_ext  = (SEXT_IMM != 0) ? {{(DATA_W-9){ir[8]}}, ir[8:0]}
                                      : {{(DATA_W-9){1'b0}}, ir[8:0]};

    regfile_bypass #(
        .DATA_W (DATA_W),
        .NREG   (NREG)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rd_idx),
        .rdata_a (rd_data),
        .raddr_b (rs_idx),
        .rdata_b (rs_data),
        .we      (wb_en && !wb_nowrite),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    // A writeback (including a squash) releases its register in the same cycle it arrives.
    assign wb_clr_mask  = wb_en ? (NREG'(1) << wb_addr) : '0;
    assign live_pending = pending & ~wb_clr_mask;
    assign hazard       = (ctrl.use_rd && live_pending[rd_idx]) ||
                          (ctrl.use_rs && live_pending[rs_idx]);

    assign accept   = in_valid && in_ready;
    assign issue    = out_valid && out_ready && !flush;
    assign set_mask = (issue && (rd_sel != '0)) ? (NREG'(1) << rd_sel) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RUN:    if (issue && ctrl.is_halt) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
        endcase
    end

    always_comb begin
        halted    = (state == ST_HALTED);
        out_valid = ir_valid && !hazard && (state == ST_RUN);
        in_ready  = (state == ST_RUN) && !flush && (!ir_valid || (out_valid && out_ready));
    end

    // Flush wins over everything; an accept in the issue cycle refills without a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= '0;
            ir_pc    <= '0;
            ir_valid <= 1'b0;
        end else if (flush) begin
            ir_valid <= 1'b0;
        end else if (accept) begin
            ir       <= inst;
            ir_pc    <= pc;
            ir_valid <= 1'b1;
        end else if (issue) begin
            ir_valid <= 1'b0;
        end
    end

    // Set takes priority over clear when issue and writeback name the same register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~wb_clr_mask) | set_mask;
        end
    end

    always_comb begin
        is_eq    = 1'b0;
        mem_w    = 1'b0;
        pc_w     = 1'b0;
        is_ldi   = 1'b0;
        is_ld_st = 1'b0;
        is_jump  = 1'b0;
        alu_op   = ALU_ADD;
        rd_addr  = '0;
        source1  = '0;
        source2  = '0;
        rd_val   = '0;
        rs_val   = '0;
        pc_out   = '0;
        if (out_valid) begin
            is_eq    = ctrl.is_eq;
            mem_w    = ctrl.mem_w;
            pc_w     = ctrl.pc_w;
            is_ldi   = ctrl.is_ldi;
            is_ld_st = ctrl.is_ld_st;
            is_jump  = ctrl.is_jump;
            alu_op   = ctrl.alu_op;
            rd_addr  = rd_sel;
        end
        if (ir_valid) begin
            rd_val = rd_data;
            rs_val = rs_data;
            pc_out = ir_pc;
            case (ctrl.src1_sel)
                SRC1_ZERO: source1 = '0;
                SRC1_RD:   source1 = rd_data;
                SRC1_RS:   source1 = rs_data;
                SRC1_PC:   source1 = ir_pc;
            endcase
            case (ctrl.src2_sel)
                SRC2_RS:   source2 = rs_data;
                SRC2_IMM:  source2 = imm_ext;
                SRC2_DISP: source2 = disp_ext;
                SRC2_ONE:  source2 = DATA_W'(1);
                default:   source2 = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// Directed scoreboard bench for decode_pipe: a 16-bit sign-extending instance for the
// main paths and a 32-bit, 16-register zero-extending instance for the squash path.
module tb_decode_pipe;

    typedef struct packed {
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] pc;
        logic [1:0]  alu;
        logic [2:0]  rd;
        logic [5:0]  flags;
    } exp_t;

    exp_t sb [$];
    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [15:0] inst, pc;
    logic        is_eq, mem_w, pc_w, is_ldi, is_ld_st, is_jump, halted;
    logic [1:0]  alu_op;
    logic [2:0]  rd_addr;
    logic [15:0] source1, source2, rd_val, rs_val, pc_out;
    logic        wb_en, wb_nowrite;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
    logic [15:0] b_inst;
    logic [31:0] b_pc;
    logic        b_is_eq, b_mem_w, b_pc_w, b_is_ldi, b_is_ld_st, b_is_jump, b_halted;
    logic [1:0]  b_alu_op;
    logic [3:0]  b_rd_addr;
    logic [31:0] b_source1, b_source2, b_rd_val, b_rs_val, b_pc_out;
    logic        b_wb_en, b_wb_nowrite;
    logic [3:0]  b_wb_addr;
    logic [31:0] b_wb_data;

    decode_pipe #(.DATA_W(16), .NREG(8), .SEXT_IMM(1)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .inst(inst), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .is_eq(is_eq), .mem_w(mem_w), .pc_w(pc_w), .is_ldi(is_ldi),
        .is_ld_st(is_ld_st), .is_jump(is_jump), .halted(halted),
        .alu_op(alu_op), .rd_addr(rd_addr),
        .source1(source1), .source2(source2), .rd_val(rd_val), .rs_val(rs_val),
        .pc_out(pc_out),
        .wb_en(wb_en), .wb_nowrite(wb_nowrite), .wb_addr(wb_addr), .wb_data(wb_data),
        .flush(flush)
    );

    decode_pipe #(.DATA_W(32), .NREG(16), .SEXT_IMM(0)) dut_wide (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .inst(b_inst), .pc(b_pc),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .is_eq(b_is_eq), .mem_w(b_mem_w), .pc_w(b_pc_w), .is_ldi(b_is_ldi),
        .is_ld_st(b_is_ld_st), .is_jump(b_is_jump), .halted(b_halted),
        .alu_op(b_alu_op), .rd_addr(b_rd_addr),
        .source1(b_source1), .source2(b_source2), .rd_val(b_rd_val), .rs_val(b_rs_val),
        .pc_out(b_pc_out),
        .wb_en(b_wb_en), .wb_nowrite(b_wb_nowrite), .wb_addr(b_wb_addr), .wb_data(b_wb_data),
        .flush(b_flush)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] s1, input logic [15:0] s2,
                                input logic [15:0] p, input logic [1:0] alu,
                                input logic [2:0] rd, input logic [5:0] flags);
        exp_t e;
        e.s1 = s1; e.s2 = s2; e.pc = p; e.alu = alu; e.rd = rd; e.flags = flags;
        return e;
    endfunction

    task automatic applyStimulus(input logic [15:0] i, input logic [15:0] p,
                                 input bit push, input exp_t e);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checkVal("in_ready_wait", in_ready, 1);
        in_valid = 1'b1;
        inst     = i;
        pc       = p;
        if (push) sb.push_back(e);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checkVal({tag, ".out_valid"}, out_valid, 1);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checkVal({tag, ".source1"}, source1, e.s1);
        checkVal({tag, ".source2"}, source2, e.s2);
        checkVal({tag, ".pc_out"}, pc_out, e.pc);
        checkVal({tag, ".alu_op"}, alu_op, e.alu);
        checkVal({tag, ".rd_addr"}, rd_addr, e.rd);
        checkVal({tag, ".flags"}, {is_eq, mem_w, pc_w, is_ldi, is_ld_st, is_jump}, e.flags);
        tick();
    endtask

    task automatic wbWrite(input logic [2:0] a, input logic [15:0] d);
        wb_en = 1'b1; wb_addr = a; wb_data = d; wb_nowrite = 1'b0;
        tick();
        wb_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired observed=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 0; inst = 0; pc = 0; out_ready = 1; flush = 0;
        wb_en = 0; wb_nowrite = 0; wb_addr = 0; wb_data = 0;
        b_in_valid = 0; b_inst = 0; b_pc = 0; b_out_ready = 1; b_flush = 0;
        b_wb_en = 0; b_wb_nowrite = 0; b_wb_addr = 0; b_wb_data = 0;
        repeat (2) tick();
        checkVal("rst.out_valid", out_valid, 0);
        checkVal("rst.halted", halted, 0);
        checkVal("rst.source1", source1, 0);
        checkVal("rst.rd_addr", rd_addr, 0);
        checkVal("rst.pc_out", pc_out, 0);
        rst = 1'b0;
        tick();
        checkVal("rst.in_ready", in_ready, 1);

        wbWrite(3'd2, 16'd5);
        applyStimulus(16'h5403, 16'h0100, 1, mk(16'd5, 16'd3, 16'h0100, 2'b00, 3'd2, 6'b0));
        checkOutput("addi");
        wbWrite(3'd2, 16'd8);
        wbWrite(3'd1, 16'd7);
        wbWrite(3'd0, 16'h0055);

        applyStimulus(16'h1280, 16'h0102, 1, mk(16'd7, 16'd8, 16'h0102, 2'b00, 3'd1, 6'b0));
        checkOutput("add");
        applyStimulus(16'h2640, 16'h0104, 1, mk(16'd0, 16'd15, 16'h0104, 2'b01, 3'd3, 6'b0));
        for (int k = 0; k < 3; k++) begin
            checkVal("sub.stall", out_valid, 0);
            tick();
        end
        wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'd15;
        #1;
        checkOutput("sub");
        wb_en = 1'b0;

        applyStimulus(16'h5801, 16'h0106, 1, mk(16'd9, 16'd1, 16'h0106, 2'b00, 3'd4, 6'b0));
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'd9;
        #1;
        checkOutput("addi4");
        wb_en = 1'b0;
        applyStimulus(16'h7800, 16'h0108, 1, mk(16'd10, 16'd1, 16'h0108, 2'b00, 3'd4, 6'b0));
        for (int k = 0; k < 2; k++) begin
            checkVal("incr.stall", out_valid, 0);
            tick();
        end
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'd10;
        #1;
        checkOutput("incr");
        wb_en = 1'b0;

        applyStimulus(16'hC03F, 16'h0010, 1, mk(16'h0010, 16'hFFFF, 16'h0010, 2'b00, 3'd0, 6'b101000));
        checkOutput("beq");
        applyStimulus(16'hE105, 16'h0040, 1, mk(16'h0040, 16'hFF05, 16'h0040, 2'b00, 3'd0, 6'b001001));
        checkOutput("jump");
        applyStimulus(16'h9CAB, 16'h0042, 1, mk(16'h0000, 16'h00AB, 16'h0042, 2'b00, 3'd6, 6'b000100));
        checkOutput("ldi");

        out_ready = 1'b0;
        applyStimulus(16'hAA05, 16'h0044, 0, '0);
        checkVal("ld.r0_zero", source1, 0);
        for (int k = 0; k < 3; k++) begin
            checkVal("ld.hold_valid", out_valid, 1);
            checkVal("ld.hold_in_ready", in_ready, 0);
            checkVal("ld.hold_source2", source2, 16'd5);
            checkVal("ld.hold_rd_addr", rd_addr, 3'd5);
            tick();
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        checkVal("flush.out_valid", out_valid, 0);
        checkVal("flush.rd_addr", rd_addr, 0);
        out_ready = 1'b1;
        applyStimulus(16'hBABE, 16'h0046, 1, mk(16'd8, 16'hFFFE, 16'h0046, 2'b00, 3'd0, 6'b010010));
        checkOutput("st");

        applyStimulus(16'hF000, 16'h0048, 1, mk(16'h0, 16'h0, 16'h0048, 2'b00, 3'd0, 6'b0));
        checkOutput("halt");
        in_valid = 1'b1; inst = 16'h1280; pc = 16'h004A;
        for (int k = 0; k < 3; k++) begin
            checkVal("halt.halted", halted, 1);
            checkVal("halt.in_ready", in_ready, 0);
            checkVal("halt.out_valid", out_valid, 0);
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checkVal("rerst.halted", halted, 0);
        checkVal("rerst.out_valid", out_valid, 0);
        checkVal("rerst.pc_out", pc_out, 0);
        tick();
        rst = 1'b0;
        #1;
        checkVal("rerst.in_ready", in_ready, 1);

        checkVal("wide.in_ready", b_in_ready, 1);
        b_in_valid = 1'b1; b_inst = 16'h5FFF; b_pc = 32'h0000_1000;
        tick();
        b_in_valid = 1'b0;
        checkVal("wide.addi_valid", b_out_valid, 1);
        checkVal("wide.addi_source2", b_source2, 32'h0000_01FF);
        checkVal("wide.addi_rd_addr", b_rd_addr, 4'd7);
        tick();
        b_in_valid = 1'b1; b_inst = 16'h7E00; b_pc = 32'h0000_1002;
        tick();
        b_in_valid = 1'b0;
        checkVal("wide.incr_stall", b_out_valid, 0);
        b_wb_en = 1'b1; b_wb_nowrite = 1'b1; b_wb_addr = 4'd7; b_wb_data = 32'h0000_DEAD;
        #1;
        checkVal("wide.squash_valid", b_out_valid, 1);
        checkVal("wide.squash_source1", b_source1, 32'h0);
        tick();
        b_wb_en = 1'b0; b_wb_nowrite = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
